serial_subtractor_8bit: RTL



---
 rtl/serial_subtractor_8bit.sv | 79 +++++++
 1 files changed

// File: rtl/serial_subtractor_8bit.sv
// serial_subtractor_8bit: bit-serial a - b - bin, LSB first, with start/busy/done handshake.
// Optional macro SERIAL_SUB_SAT_EN clamps a borrowing result to zero.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CW-1:0]    cnt;
    logic             brw, d, brw_next;

    assign busy     = state != IDLE;
    assign d        = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    brw   <= bin;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    res   <= {d, res[WIDTH-1:1]};
                    brw   <= brw_next;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == LAST) ? DONE : SHIFT;
                end
                DONE: begin
`ifdef SERIAL_SUB_SAT_EN
                    diff <= brw ? '0 : res;
                    zero <= brw | (res == '0);
`else
                    diff <= res;
                    zero <= res == '0;
`endif
                    bout  <= brw;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
